// File: rtl/rv32i_regfile_mp.sv
// Multi-read-port integer register file with hardwired x0 and a clear sweep.
// Optional macro RF_WR_BYPASS_EN: same-edge read of a written address sees the new data.
module rv32i_regfile_mp #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_RD_PORTS-1:0]        i_rd_en,
  input  logic [NUM_RD_PORTS*$clog2(NUM_REGS)-1:0] i_rd_addr,
  output logic [NUM_RD_PORTS*XLEN-1:0]   o_rd_data,
  output logic [NUM_RD_PORTS-1:0]        o_rd_valid,
  input  logic                           i_wr_en,
  input  logic [$clog2(NUM_REGS)-1:0]    i_wr_addr,
  input  logic [XLEN-1:0]                i_wr_data,
  output logic                           o_wr_valid,
  input  logic                           i_clear,
  output logic                           o_busy
);

  localparam int AW = $clog2(NUM_REGS);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SWEEP = 1'b1;

  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] ZERO = '0;

  logic                      r_state;
  logic [AW-1:0]             r_idx;
  logic [XLEN-1:0]           r_regs [NUM_REGS];
  logic [NUM_RD_PORTS*XLEN-1:0] r_rd_data;
  logic [NUM_RD_PORTS-1:0]   r_rd_valid;
  logic                      r_wr_valid;

  logic w_busy;
  logic w_wr_go;

  assign w_busy  = (r_state == ST_SWEEP);
  assign w_wr_go = i_wr_en && !w_busy;

  assign o_busy     = w_busy;
  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_wr_valid = r_wr_valid;

  // Clear FSM: IDLE starts a sweep from index 1; SWEEP walks up to the last register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= ZERO;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_clear) begin
            r_state <= ST_SWEEP;
            r_idx   <= ONE;
          end
        end
        ST_SWEEP: begin
          r_idx <= r_idx + ONE;
          if (r_idx == LAST) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Storage: writeback port when idle, sweep zeroing when busy; x0 never written.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_busy) begin
      r_regs[r_idx] <= '0;
    end else if (w_wr_go && (i_wr_addr != ZERO)) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Write acknowledge, pulses even for discarded x0 writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_valid <= 1'b0;
    end else begin
      r_wr_valid <= w_wr_go;
    end
  end

  // Registered read ports; data holds between reads, valid pulses per request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        r_rd_valid[p] <= i_rd_en[p] && !w_busy;
        if (i_rd_en[p] && !w_busy) begin
          if (i_rd_addr[p*AW +: AW] == ZERO) begin
            r_rd_data[p*XLEN +: XLEN] <= '0;
`ifdef RF_WR_BYPASS_EN
          end else if (i_wr_en && (i_wr_addr == i_rd_addr[p*AW +: AW])) begin
            r_rd_data[p*XLEN +: XLEN] <= i_wr_data;
`endif
          end else begin
            r_rd_data[p*XLEN +: XLEN] <= r_regs[i_rd_addr[p*AW +: AW]];
          end
        end
      end
    end
  end

endmodule
